// File: rtl/data_mem_ctrl.sv
// Data-memory controller: latches one core load/store and turns it into a single
// byte-laned SRAM word access with a fixed number of wait states.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wr_data,
  input  logic [3:0]        i_byte_en,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  output logic              o_ready,
  output logic [31:0]       o_rd_data,
  output logic              o_err,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_is_load;
  logic [31:0]         r_rd_data;
  logic                r_err;
  logic                r_mem_cs;
  logic                r_mem_we;
  logic [3:0]          r_mem_be;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic                w_req;
  logic [31:0]         w_off;
  logic [31:0]         w_word;
  logic [32:0]         w_lim;
  logic                w_be_ok;
  logic                w_range_ok;
  logic                w_legal;
  logic [31:0]         w_lane_mask;

  assign w_req  = i_rd_en | i_wr_en;
  assign w_off  = i_addr - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign w_lim  = 33'd1 << ADDR_W;

  always_comb begin
    w_be_ok = 1'b0;
    case (i_byte_en)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
      default:                   w_be_ok = 1'b0;
    endcase
  end

  assign w_range_ok = (i_addr >= BASE_ADDR) && ({1'b0, w_word} < w_lim);
  assign w_legal    = w_be_ok && w_range_ok && !(i_rd_en && i_wr_en);

  assign w_lane_mask = {{8{r_mem_be[3]}}, {8{r_mem_be[2]}},
                        {8{r_mem_be[1]}}, {8{r_mem_be[0]}}};

  assign o_ready     = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign o_rd_data   = r_rd_data;
  assign o_err       = r_err;
  assign o_mem_cs    = r_mem_cs;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // SRAM controls are registered so they are asserted for exactly the ACCESS
  // cycle; read data is captured on the last WAIT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_load <= i_rd_en;
            r_err     <= !w_legal;
            if (w_legal) begin
              r_state     <= S_ACCESS;
              r_mem_cs    <= 1'b1;
              r_mem_we    <= i_wr_en;
              r_mem_be    <= i_byte_en;
              r_mem_addr  <= w_word[ADDR_W-1:0];
              r_mem_wdata <= i_wr_data;
            end else begin
              r_state <= S_DONE;
              if (i_rd_en) r_rd_data <= '0;
            end
          end
        end
        S_ACCESS: begin
          r_mem_cs <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= 4'(WAIT_STATES - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            if (r_is_load) r_rd_data <= i_mem_rdata & w_lane_mask;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
